gated_toggle_array: RTL and testbench



---
 rtl/gta_pkg.sv | 25 ++
 rtl/gta_channel.sv | 84 ++++++++
 rtl/gated_toggle_array.sv | 61 ++++++
 tb/tb_gated_toggle_array.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gta_pkg.sv
// Shared types and next-state function for gated_toggle_array.
package gta_pkg;

    typedef enum logic [1:0] {
        GTA_NANDNOR = 2'b00,
        GTA_ORNOR   = 2'b01,
        GTA_TOGGLE  = 2'b10,
        GTA_CLEAR   = 2'b11
    } gta_mode_e;

    // Next core state for one channel given operands a, b and current state q.
    function automatic logic gta_next(gta_mode_e mode, logic a, logic b, logic q);
        logic w_next;
        w_next = 1'b0;
        unique case (mode)
            GTA_NANDNOR: w_next = a & b & ~q;
            GTA_ORNOR:   w_next = (a | b) & ~q;
            GTA_TOGGLE:  w_next = q ^ (a & b);
            GTA_CLEAR:   w_next = 1'b0;
            default:     w_next = 1'b0;
        endcase
        return w_next;
    endfunction

endpackage

// File: rtl/gta_channel.sv
// One channel: core state bit, output delay chain and saturating rise counter.
// The counter exists only when GTA_RISE_CNT_EN is defined; otherwise o_cnt is 0.
module gta_channel
    import gta_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_a,
    input  logic             i_b,
    input  gta_mode_e        i_mode,
    input  logic             i_en,
    input  logic             i_cnt_clr,
    output logic             o_out,
    output logic [CNT_W-1:0] o_cnt
);

    logic r_q;
    logic w_q_next;

    // Core next state: hold unless enabled.
    always_comb begin
        w_q_next = r_q;
        if (i_en) begin
            w_q_next = gta_next(i_mode, i_a, i_b, r_q);
        end
    end

    // Core state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= w_q_next;
        end
    end

    generate
        if (PIPE_DEPTH == 0) begin : g_no_pipe
            assign o_out = r_q;
        end else begin : g_pipe
            logic [PIPE_DEPTH-1:0] r_pipe;

            // Free-running delay chain; stage 0 takes the core state.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe[0] <= r_q;
                    for (int k = 1; k < int'(PIPE_DEPTH); k++) begin
                        r_pipe[k] <= r_pipe[k-1];
                    end
                end
            end

            assign o_out = r_pipe[PIPE_DEPTH-1];
        end
    endgenerate

`ifdef GTA_RISE_CNT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             w_rise;

    assign w_rise = ~r_q & w_q_next;

    // Rise counter: clear beats a simultaneous rise; sticks at all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_rise && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = i_cnt_clr;
    assign o_cnt            = '0;
`endif

endmodule

// File: rtl/gated_toggle_array.sv
// Multi-channel gated feedback cell array with pipelined outputs.
// Optional per-channel rise counters are built when GTA_RISE_CNT_EN is defined.
module gated_toggle_array
    import gta_pkg::*;
#(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned PIPE_DEPTH = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                      iccad_clk,
    input  logic                      iccad_rst,
    input  logic [CHANNELS-1:0]       inp1,
    input  logic [CHANNELS-1:0]       inp2,
    input  logic [1:0]                mode,
    input  logic                      clk_en,
    input  logic                      cnt_clr,
    output logic [CHANNELS-1:0]       out,
    output logic                      out_valid,
    output logic [CHANNELS*CNT_W-1:0] rise_cnt
);

    gta_mode_e w_mode;
    assign w_mode = gta_mode_e'(mode);

    // Enable delayed by PIPE_DEPTH+1 so it lines up with the data it produced.
    logic [PIPE_DEPTH:0] r_valid;

    // Valid shift chain.
    always_ff @(posedge iccad_clk) begin
        if (iccad_rst) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= clk_en;
            for (int k = 1; k <= int'(PIPE_DEPTH); k++) begin
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    assign out_valid = r_valid[PIPE_DEPTH];

    generate
        for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
            gta_channel #(
                .PIPE_DEPTH (PIPE_DEPTH),
                .CNT_W      (CNT_W)
            ) u_ch (
                .i_clk     (iccad_clk),
                .i_rst     (iccad_rst),
                .i_a       (inp1[g]),
                .i_b       (inp2[g]),
                .i_mode    (w_mode),
                .i_en      (clk_en),
                .i_cnt_clr (cnt_clr),
                .o_out     (out[g]),
                .o_cnt     (rise_cnt[g*CNT_W +: CNT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_gated_toggle_array.sv
// Directed bench for gated_toggle_array with a delay-line reference model.
// Counter expectations follow GTA_RISE_CNT_EN (zero when undefined).
module tb_gated_toggle_array;

    localparam int CH = 4;
    localparam int PD = 2;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   a, b;
    logic [1:0]      md;
    logic            en, clr;
    logic [CH-1:0]   out;
    logic            out_valid;
    logic [CH*CW-1:0] rise_cnt;

    gated_toggle_array #(
        .CHANNELS   (CH),
        .PIPE_DEPTH (PD),
        .CNT_W      (CW)
    ) dut (
        .iccad_clk (clk),
        .iccad_rst (rst),
        .inp1      (a),
        .inp2      (b),
        .mode      (md),
        .clk_en    (en),
        .cnt_clr   (clr),
        .out       (out),
        .out_valid (out_valid),
        .rise_cnt  (rise_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;

    // Reference model state
    logic [CH-1:0]    q_m;
    int               cnt_m [CH];
    logic [CH-1:0]    qh [$];
    logic             vh [$];
    logic [CH-1:0]    exp_out;
    logic             exp_v;
    logic [CH*CW-1:0] exp_cnt;

    function automatic logic [CH-1:0] f_next(logic [1:0] m, logic [CH-1:0] x, logic [CH-1:0] y,
                                             logic [CH-1:0] q);
        case (m)
            2'd0:    return x & y & ~q;
            2'd1:    return (x | y) & ~q;
            2'd2:    return q ^ (x & y);
            default: return '0;
        endcase
    endfunction

    task automatic model_update();
        logic [CH-1:0] nq;
        if (rst) begin
            q_m = '0;
            for (int i = 0; i < CH; i++) cnt_m[i] = 0;
            qh.delete();
            vh.delete();
            for (int i = 0; i <= PD; i++) begin
                qh.push_back('0);
                vh.push_back(1'b0);
            end
        end else begin
            nq = en ? f_next(md, a, b, q_m) : q_m;
            for (int i = 0; i < CH; i++) begin
                if (clr) cnt_m[i] = 0;
                else if (!q_m[i] && nq[i] && cnt_m[i] < CMAX) cnt_m[i]++;
            end
            q_m = nq;
            qh.push_back(nq);
            void'(qh.pop_front());
            vh.push_back(en);
            void'(vh.pop_front());
        end
        exp_out = qh[0];
        exp_v   = vh[0];
        exp_cnt = '0;
`ifdef GTA_RISE_CNT_EN
        for (int i = 0; i < CH; i++) exp_cnt[i*CW +: CW] = CW'(cnt_m[i]);
`endif
    endtask

    // Advance n edges; model sees the same inputs the DUT samples.
    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            model_update();
            #2;
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("model_out", 32'(out), 32'(exp_out));
            check("model_valid", 32'(out_valid), 32'(exp_v));
            check("model_cnt", 32'(rise_cnt), 32'(exp_cnt));
        end
    end

    function automatic logic [31:0] cnt_lit(logic [31:0] v);
`ifdef GTA_RISE_CNT_EN
        return v;
`else
        return 32'(v & 32'h0);
`endif
    endfunction

    initial begin
        rst = 1'b1; a = '0; b = '0; md = 2'd0; en = 1'b0; clr = 1'b0;
        step(1);
        chk_on = 1;
        check("reset_out", 32'(out), 32'h0);
        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_cnt", 32'(rise_cnt), 32'h0);

        // 1: NANDNOR with all-ones operands
        rst = 1'b0; md = 2'd0; en = 1'b1; a = 4'hF; b = 4'hF;
        step(2);
        check("t1_out_edge2", 32'(out), 32'h0);
        check("t1_valid_edge2", 32'(out_valid), 32'h0);
        step(1);
        check("t1_out_edge3", 32'(out), 32'hF);
        check("t1_valid_edge3", 32'(out_valid), 32'h1);
        step(3);
        check("t1_out_edge6", 32'(out), 32'h0);
        check("t1_cnt_edge6", 32'(rise_cnt), cnt_lit(32'h03030303));

        // 2: TOGGLE on selected channels
        en = 1'b0; clr = 1'b1;
        step(1);
        clr = 1'b0; en = 1'b1; md = 2'd2; a = 4'b0101; b = 4'b0111;
        step(3);
        check("t2_out_mid", 32'(out), 32'h5);
        step(1);
        en = 1'b0;
        step(2);
        check("t2_out_final", 32'(out), 32'h0);
        check("t2_cnt", 32'(rise_cnt), cnt_lit(32'h00020002));

        // 3: sparse enables, NANDNOR
        md = 2'd0; a = 4'hF; b = 4'hF;
        for (int p = 0; p < 3; p++) begin
            en = 1'b1;
            step(1);
            en = 1'b0;
            step(1);
            check("t3_valid_low", 32'(out_valid), 32'h0);
            step(1);
            check("t3_valid_pulse", 32'(out_valid), 32'h1);
            check("t3_out", 32'(out), (p % 2 == 0) ? 32'hF : 32'h0);
        end
        step(1);
        check("t3_valid_after", 32'(out_valid), 32'h0);

        // 4: saturation, then clear on a rising edge
        clr = 1'b1;
        step(1);
        clr = 1'b0; md = 2'd2; en = 1'b1;
        step(2 * CMAX + 10);
        check("t4_saturate", 32'(rise_cnt), cnt_lit(32'hFFFFFFFF));
        for (int k = 0; k < 4 && q_m != 4'h0; k++) step(1);
        check("t4_q_low", 32'(q_m), 32'h0);
        clr = 1'b1;
        step(1);
        check("t4_clr_prio", 32'(rise_cnt), 32'h0);
        clr = 1'b0;
        step(2);
        check("t4_recount", 32'(rise_cnt), cnt_lit(32'h01010101));

        // 5: mid-stream reset with a full pipeline of ones
        for (int k = 0; k < 4 && q_m != 4'hF; k++) step(1);
        a = 4'h0;
        step(3);
        check("t5_full_out", 32'(out), 32'hF);
        check("t5_full_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        step(1);
        check("t5_rst_out", 32'(out), 32'h0);
        check("t5_rst_valid", 32'(out_valid), 32'h0);
        check("t5_rst_cnt", 32'(rise_cnt), 32'h0);
        rst = 1'b0; md = 2'd0; a = 4'hF; b = 4'hF; en = 1'b1;
        step(2);
        check("t5_pre_out", 32'(out), 32'h0);
        step(1);
        check("t5_post_out", 32'(out), 32'hF);
        check("t5_post_valid", 32'(out_valid), 32'h1);

        // CLEAR mode and ORNOR with single operand
        md = 2'd3;
        step(1);
        md = 2'd1; a = 4'b1010; b = 4'b0000;
        step(4);
        check("ornor_q", 32'(q_m), 32'h0);

        @(negedge clk);
        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
